// File: rtl/tx_conn_resolver.sv
// Transmit connection resolver: turns a (connectionId, length) request into a
// full UDP/IP/MAC header descriptor via a reverse lookup in the connection manager.
module tx_conn_resolver #(
    parameter int WAYS    = 4,
    parameter int MAX_LEN = 1472,
    localparam int CONN_ID_WIDTH = 16 + $clog2(WAYS)
) (
    input  logic                     s00_axis_aclk,
    input  logic                     s00_axis_aresetn,

    input  logic                     s00_axis_req_valid,
    output logic                     s00_axis_req_ready,
    input  logic [CONN_ID_WIDTH-1:0] s00_axis_req_connectionId,
    input  logic [15:0]              s00_axis_req_length,

    output logic                     m00_axis_rv_lookup_valid,
    input  logic                     m00_axis_rv_lookup_ready,
    output logic [CONN_ID_WIDTH-1:0] m00_axis_rv_lookup_connectionId,

    input  logic                     s01_axis_rv_lookup_valid,
    output logic                     s01_axis_rv_lookup_ready,
    input  logic                     s01_axis_rv_lookup_hit,
    input  logic [47:0]              s01_axis_rv_lookup_macAddr,
    input  logic [15:0]              s01_axis_rv_lookup_udpPort,
    input  logic [31:0]              s01_axis_rv_lookup_ipAddr,

    output logic                     m01_axis_hdr_valid,
    input  logic                     m01_axis_hdr_ready,
    output logic [47:0]              m01_axis_hdr_macAddr,
    output logic [31:0]              m01_axis_hdr_ipAddr,
    output logic [15:0]              m01_axis_hdr_udpPort,
    output logic [15:0]              m01_axis_hdr_length,
    output logic [CONN_ID_WIDTH-1:0] m01_axis_hdr_connectionId,

    output logic                     drop_pulse,
    output logic [15:0]              drop_count
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] LOOKUP   = 2'd1;
    localparam logic [1:0] WAIT_RSP = 2'd2;
    localparam logic [1:0] EMIT     = 2'd3;

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    logic [1:0]               state_q;
    logic [1:0]               state_d;
    logic                     req_ready_q;
    logic                     drop;
    logic                     req_hs;
    logic                     rsp_hs;
    logic                     len_ok;
    logic [CONN_ID_WIDTH-1:0] conn_id_q;
    logic [15:0]              length_q;
    logic [47:0]              mac_q;
    logic [31:0]              ip_q;
    logic [15:0]              port_q;

    assign req_hs = s00_axis_req_valid & req_ready_q;
    assign rsp_hs = s01_axis_rv_lookup_valid & (state_q == WAIT_RSP);
    assign len_ok = (s00_axis_req_length != 16'd0) &&
                    (s00_axis_req_length <= MAX_LEN_W);

    always_comb begin
        state_d = state_q;
        drop    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_hs) begin
                    if (len_ok) state_d = LOOKUP;
                    else        drop    = 1'b1;
                end
            end
            LOOKUP: begin
                if (m00_axis_rv_lookup_ready) state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (rsp_hs) begin
                    if (s01_axis_rv_lookup_hit) begin
                        state_d = EMIT;
                    end else begin
                        state_d = IDLE;
                        drop    = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (m01_axis_hdr_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is registered off the next state so it is 0 throughout reset
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            drop_pulse  <= 1'b0;
            drop_count  <= 16'd0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == IDLE);
            drop_pulse  <= drop;
            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            conn_id_q <= '0;
            length_q  <= 16'd0;
            mac_q     <= 48'd0;
            ip_q      <= 32'd0;
            port_q    <= 16'd0;
        end else begin
            if (state_q == IDLE && req_hs && len_ok) begin
                conn_id_q <= s00_axis_req_connectionId;
                length_q  <= s00_axis_req_length;
            end
            if (rsp_hs && s01_axis_rv_lookup_hit) begin
                mac_q  <= s01_axis_rv_lookup_macAddr;
                ip_q   <= s01_axis_rv_lookup_ipAddr;
                port_q <= s01_axis_rv_lookup_udpPort;
            end
        end
    end

    assign s00_axis_req_ready              = req_ready_q;
    assign m00_axis_rv_lookup_valid        = (state_q == LOOKUP);
    assign m00_axis_rv_lookup_connectionId = conn_id_q;
    assign s01_axis_rv_lookup_ready        = (state_q == WAIT_RSP);
    assign m01_axis_hdr_valid              = (state_q == EMIT);
    assign m01_axis_hdr_macAddr            = mac_q;
    assign m01_axis_hdr_ipAddr             = ip_q;
    assign m01_axis_hdr_udpPort            = port_q;
    assign m01_axis_hdr_length             = length_q;
    assign m01_axis_hdr_connectionId       = conn_id_q;

endmodule

// File: tb/tb_tx_conn_resolver.sv
// Directed bench for tx_conn_resolver: hit, miss, length drops, stall,
// reset mid-transaction and drop counter saturation.
module tb_tx_conn_resolver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [17:0] req_id;
    logic [15:0] req_len;
    logic        lk_valid;
    logic        lk_ready;
    logic [17:0] lk_id;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic [47:0] rsp_mac;
    logic [15:0] rsp_port;
    logic [31:0] rsp_ip;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [47:0] hdr_mac;
    logic [31:0] hdr_ip;
    logic [15:0] hdr_port;
    logic [15:0] hdr_len;
    logic [17:0] hdr_id;
    logic        drop_pulse;
    logic [15:0] drop_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tx_conn_resolver dut (
        .s00_axis_aclk                   (clk),
        .s00_axis_aresetn                (rst_n),
        .s00_axis_req_valid              (req_valid),
        .s00_axis_req_ready              (req_ready),
        .s00_axis_req_connectionId       (req_id),
        .s00_axis_req_length             (req_len),
        .m00_axis_rv_lookup_valid        (lk_valid),
        .m00_axis_rv_lookup_ready        (lk_ready),
        .m00_axis_rv_lookup_connectionId (lk_id),
        .s01_axis_rv_lookup_valid        (rsp_valid),
        .s01_axis_rv_lookup_ready        (rsp_ready),
        .s01_axis_rv_lookup_hit          (rsp_hit),
        .s01_axis_rv_lookup_macAddr      (rsp_mac),
        .s01_axis_rv_lookup_udpPort      (rsp_port),
        .s01_axis_rv_lookup_ipAddr       (rsp_ip),
        .m01_axis_hdr_valid              (hdr_valid),
        .m01_axis_hdr_ready              (hdr_ready),
        .m01_axis_hdr_macAddr            (hdr_mac),
        .m01_axis_hdr_ipAddr             (hdr_ip),
        .m01_axis_hdr_udpPort            (hdr_port),
        .m01_axis_hdr_length             (hdr_len),
        .m01_axis_hdr_connectionId       (hdr_id),
        .drop_pulse                      (drop_pulse),
        .drop_count                      (drop_count)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request at a negedge; returns just after the accepting edge
    task automatic do_req(input logic [17:0] id, input logic [15:0] len);
        int n;
        req_valid = 1'b1;
        req_id    = id;
        req_len   = len;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("req_timeout", 0, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // From LOOKUP: accept lookup, deliver one response
    task automatic do_lookup(input logic hit, input logic [47:0] mac,
                             input logic [31:0] ip, input logic [15:0] port);
        lk_ready = 1'b1;
        @(negedge clk);
        lk_ready = 1'b0;
        check("wait_rsp_ready", rsp_ready, 1);
        check("lk_valid_drop", lk_valid, 0);
        rsp_valid = 1'b1;
        rsp_hit   = hit;
        rsp_mac   = mac;
        rsp_ip    = ip;
        rsp_port  = port;
        @(negedge clk);
        rsp_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_id = '0; req_len = '0;
        lk_ready = 1'b0;
        rsp_valid = 1'b0; rsp_hit = 1'b0;
        rsp_mac = '0; rsp_port = '0; rsp_ip = '0;
        hdr_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_lk_valid", lk_valid, 0);
        check("rst_rsp_ready", rsp_ready, 0);
        check("rst_hdr_valid", hdr_valid, 0);
        check("rst_drop_cnt", drop_count, 0);
        check("rst_drop_pulse", drop_pulse, 0);
        check("rst_hdr_mac", hdr_mac, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("req_ready_rise", req_ready, 1);

        // Hit path
        do_req(18'h2_0005, 16'd100);
        check("lk_valid", lk_valid, 1);
        check("lk_id", lk_id, 18'h2_0005);
        check("busy_req_ready", req_ready, 0);
        do_lookup(1'b1, 48'h0A0B_0C0D_0E0F, 32'hC0A8_0001, 16'd5000);
        check("hdr_valid", hdr_valid, 1);
        check("hdr_mac", hdr_mac, 48'h0A0B_0C0D_0E0F);
        check("hdr_ip", hdr_ip, 32'hC0A8_0001);
        check("hdr_port", hdr_port, 16'd5000);
        check("hdr_len", hdr_len, 16'd100);
        check("hdr_id", hdr_id, 18'h2_0005);
        check("emit_rsp_ready", rsp_ready, 0);
        hdr_ready = 1'b1;
        @(negedge clk);
        hdr_ready = 1'b0;
        check("hdr_done", hdr_valid, 0);
        check("idle_req_ready", req_ready, 1);
        check("hdr_mac_kept", hdr_mac, 48'h0A0B_0C0D_0E0F);

        // Miss path
        do_req(18'h1_0003, 16'd64);
        do_lookup(1'b0, 48'h1, 32'h2, 16'h3);
        check("miss_hdr_valid", hdr_valid, 0);
        check("miss_pulse", drop_pulse, 1);
        check("miss_count", drop_count, 1);
        check("miss_req_ready", req_ready, 1);
        @(negedge clk);
        check("miss_pulse_end", drop_pulse, 0);

        // Length boundaries
        do_req(18'h0_0001, 16'd0);
        check("len0_pulse", drop_pulse, 1);
        check("len0_no_lk", lk_valid, 0);
        check("len0_count", drop_count, 2);
        do_req(18'h0_0002, 16'd1473);
        check("len1473_no_lk", lk_valid, 0);
        check("len1473_count", drop_count, 3);
        do_req(18'h0_0007, 16'd1472);
        check("len1472_lk", lk_valid, 1);
        check("len1472_id", lk_id, 18'h0_0007);
        do_lookup(1'b1, 48'h1111_2222_3333, 32'h0A00_0001, 16'd53);
        check("len1472_hdr", hdr_len, 16'd1472);
        hdr_ready = 1'b1;
        @(negedge clk);
        hdr_ready = 1'b0;

        // Stalled EMIT, with a stray response that must be ignored
        do_req(18'h3_FFFF, 16'd1);
        do_lookup(1'b1, 48'hAABB_CCDD_EEFF, 32'h0102_0304, 16'hFFFF);
        rsp_valid = 1'b1; rsp_hit = 1'b1;
        rsp_mac = 48'h5; rsp_ip = 32'h6; rsp_port = 16'h7;
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", hdr_valid, 1);
            check("stall_mac", hdr_mac, 48'hAABB_CCDD_EEFF);
            check("stall_ip", hdr_ip, 32'h0102_0304);
            check("stall_port", hdr_port, 16'hFFFF);
            check("stall_len", hdr_len, 16'd1);
            check("stall_id", hdr_id, 18'h3_FFFF);
            check("stall_req_ready", req_ready, 0);
            check("stall_rsp_ready", rsp_ready, 0);
            @(negedge clk);
        end
        rsp_valid = 1'b0;
        hdr_ready = 1'b1;
        @(negedge clk);
        hdr_ready = 1'b0;
        check("stall_done", hdr_valid, 0);
        check("stall_count", drop_count, 3);

        // Reset while waiting for the lookup response
        do_req(18'h2_2222, 16'd200);
        lk_ready = 1'b1;
        @(negedge clk);
        lk_ready = 1'b0;
        check("pre_rst_wait", rsp_ready, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rsp_ready", rsp_ready, 0);
        check("arst_req_ready", req_ready, 0);
        check("arst_hdr_valid", hdr_valid, 0);
        check("arst_drop_cnt", drop_count, 0);
        check("arst_hdr_mac", hdr_mac, 0);
        check("arst_lk_id", lk_id, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_ready_back", req_ready, 1);
        do_req(18'h0_0042, 16'd512);
        do_lookup(1'b1, 48'h0000_0000_0001, 32'h7F00_0001, 16'd80);
        check("post_rst_hdr_id", hdr_id, 18'h0_0042);
        check("post_rst_port", hdr_port, 16'd80);
        hdr_ready = 1'b1;
        @(negedge clk);
        hdr_ready = 1'b0;
        check("post_rst_drop", drop_count, 0);
        check("post_rst_pulse", drop_pulse, 0);

        // Saturation: 65535 back-to-back length drops, then a miss
        do_reset();
        req_valid = 1'b1;
        req_len   = 16'd0;
        repeat (65535) @(negedge clk);
        req_valid = 1'b0;
        check("sat_count", drop_count, 16'hFFFF);
        check("sat_pulse_a", drop_pulse, 1);
        @(negedge clk);
        do_req(18'h0_0009, 16'd10);
        do_lookup(1'b0, 48'h0, 32'h0, 16'h0);
        check("sat_pulse_b", drop_pulse, 1);
        check("sat_hold", drop_count, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
